// File: rtl/hid_report_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : hid_pkg
// Description :
//   Shared definitions for the Bluetooth HID link (receiver and the
//   hid_report_tx return path): sync byte, frame length, report field
//   widths, serializer state encodings and the checksum helper.
//   Configuration macro: HID_REPORT_CHECKSUM_EN appends a checksum byte,
//   making each frame 5 bytes instead of 4.
// Revision : 1.0  initial release
// ============================================================================
package hid_pkg;

    localparam logic [7:0] HID_SYNC_BYTE = 8'hA5;

`ifdef HID_REPORT_CHECKSUM_EN
    localparam int HID_FRAME_BYTES = 5;
`else
    localparam int HID_FRAME_BYTES = 4;
`endif

    localparam int CMD_W   = 3;
    localparam int COORD_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Checksum byte is the XOR of the three payload bytes (sync excluded).
    function automatic logic [7:0] hid_checksum(input logic [7:0] b1,
                                                input logic [7:0] b2,
                                                input logic [7:0] b3);
        return b1 ^ b2 ^ b3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hid_report_tx_if.sv
`default_nettype none
// ============================================================================
// Module : hid_report_tx_if
// Description :
//   Report handshake bundle between the paint core (master) and
//   hid_report_tx (slave).
//   report_valid/report_ready : valid/ready handshake, fires on valid&&ready
//   report_cmd/x/y            : paint command and cursor coordinates
// Revision : 1.0  initial release
// ============================================================================
interface hid_report_tx_if;
    import hid_pkg::*;

    logic               report_valid;
    logic               report_ready;
    logic [CMD_W-1:0]   report_cmd;
    logic [COORD_W-1:0] report_x;
    logic [COORD_W-1:0] report_y;

    modport master (
        output report_valid, report_cmd, report_x, report_y,
        input  report_ready
    );

    modport slave (
        input  report_valid, report_cmd, report_x, report_y,
        output report_ready
    );
endinterface
`default_nettype wire

// File: rtl/hid_report_tx_uart.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_byte
// Description :
//   8N1 byte serializer, LSB first, each bit CLKS_PER_BIT clocks.
//   A byte offered while the stop bit of the previous one ends is taken on
//   that same edge, so consecutive bytes follow with no idle gap.
//   Ports: clk, rstn (sync, active-low), byte_valid/byte_data/byte_ready
//   byte handshake, tx registered serial out (idle high), byte_done strobe
//   during the last cycle of a stop bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import hid_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx,
    output logic       byte_done
);
    localparam int                 TIMER_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TIMER_W-1:0] C_TERM  = TIMER_W'(CLKS_PER_BIT - 1);

    tx_state_t          r_state,   w_state_nxt;
    logic [TIMER_W-1:0] r_timer,   w_timer_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift,   w_shift_nxt;
    logic               r_tx,      w_tx_nxt;
    logic               w_term;
    logic               w_load;

    assign w_term     = (r_timer == C_TERM);
    assign byte_done  = (r_state == ST_STOP) && w_term;
    assign byte_ready = (r_state == ST_IDLE) || byte_done;
    assign w_load     = byte_valid && byte_ready;
    assign tx         = r_tx;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        // Timer idles at 0 and restarts on every bit boundary.
        w_timer_nxt   = (r_state == ST_IDLE || w_term) ? '0 : r_timer + TIMER_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = byte_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_term) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_term) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_term) begin
                    if (w_load) begin
                        w_state_nxt = ST_START;
                        w_shift_nxt = byte_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hid_report_tx.sv
`default_nettype none
// ============================================================================
// Module : hid_report_tx
// Description :
//   Serializes paint reports {cmd,x,y} into UART frames A5,cmd,x,y[,csum]
//   on tx_pin (8N1, LSB first) for the phone app.
//   Configuration macro: HID_REPORT_CHECKSUM_EN adds B4 = B1^B2^B3.
//   Ports: clk, rstn (sync, active-low), rpt (report handshake, slave),
//   tx_pin (idle high), busy (frame in flight), frame_done (1-cycle pulse
//   when the last stop bit ends).
// Revision : 1.0  initial release
// ============================================================================
module hid_report_tx
    import hid_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic           clk,
    input  logic           rstn,
    hid_report_tx_if.slave rpt,
    output logic           tx_pin,
    output logic           busy,
    output logic           frame_done
);
    localparam logic [2:0] C_LAST_IDX = 3'(HID_FRAME_BYTES - 1);

    logic               r_busy;
    logic               r_frame_done;
    logic [2:0]         r_byte_idx;
    logic [CMD_W-1:0]   r_cmd;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    logic       w_accept;
    logic       w_last;
    logic [2:0] w_next_idx;
    logic [7:0] w_byte_data;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic       w_byte_done;

    assign w_accept   = rpt.report_valid && !r_busy;
    assign w_last     = (r_byte_idx == C_LAST_IDX);
    // Byte handed to the serializer: the sync byte when starting a frame,
    // otherwise the one after the byte currently on the line.
    assign w_next_idx = r_busy ? r_byte_idx + 3'd1 : 3'd0;
    // When idle the serializer is idle too, so an accepted report starts
    // the sync byte on the same edge (tx_pin low from the accept edge).
    assign w_byte_valid = r_busy ? !w_last : rpt.report_valid;

    always_comb begin
        w_byte_data = HID_SYNC_BYTE;
        case (w_next_idx)
            3'd1:    w_byte_data = 8'(r_cmd);
            3'd2:    w_byte_data = 8'(r_x);
            3'd3:    w_byte_data = 8'(r_y);
`ifdef HID_REPORT_CHECKSUM_EN
            3'd4:    w_byte_data = hid_checksum(8'(r_cmd), 8'(r_x), 8'(r_y));
`endif
            default: w_byte_data = HID_SYNC_BYTE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_ready (w_byte_ready),
        .tx         (tx_pin),
        .byte_done  (w_byte_done)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte_idx   <= 3'd0;
            r_cmd        <= '0;
            r_x          <= '0;
            r_y          <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_byte_idx <= 3'd0;
                r_cmd      <= rpt.report_cmd;
                r_x        <= rpt.report_x;
                r_y        <= rpt.report_y;
            end else if (r_busy) begin
                if (w_byte_valid && w_byte_ready) begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                end
                if (w_byte_done && w_last) begin
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign rpt.report_ready = !r_busy;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_hid_report_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_hid_report_tx
// Description :
//   Self-checking bench for hid_report_tx. Two instances: CLKS_PER_BIT=4
//   (main vectors) and CLKS_PER_BIT=1. tx_pin is sampled mid-bit on the
//   falling edge and decoded back into bytes.
// Revision : 1.0  initial release
// ============================================================================
module tb_hid_report_tx;

`ifdef HID_REPORT_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    typedef struct {
        logic [2:0] cmd;
        logic [5:0] x;
        logic [5:0] y;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [7:0] b4;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    logic tx4, busy4, fd4;
    logic tx1, busy1, fd1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hid_report_tx_if rif4 ();
    hid_report_tx_if rif1 ();

    hid_report_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rstn(rstn), .rpt(rif4),
        .tx_pin(tx4), .busy(busy4), .frame_done(fd4)
    );

    hid_report_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rstn(rstn), .rpt(rif1),
        .tx_pin(tx1), .busy(busy1), .frame_done(fd1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [2:0] c,
                         input logic [5:0] x, input logic [5:0] y);
        if (sel) begin
            rif1.report_valid = v; rif1.report_cmd = c; rif1.report_x = x; rif1.report_y = y;
        end else begin
            rif4.report_valid = v; rif4.report_cmd = c; rif4.report_x = x; rif4.report_y = y;
        end
    endtask

    function automatic logic get_tx(input bit sel);    return sel ? tx1 : tx4; endfunction
    function automatic logic get_busy(input bit sel);  return sel ? busy1 : busy4; endfunction
    function automatic logic get_fd(input bit sel);    return sel ? fd1 : fd4; endfunction
    function automatic logic get_ready(input bit sel);
        return sel ? rif1.report_ready : rif4.report_ready;
    endfunction

    // Offers one report (caller is at a falling edge), waits for the accept,
    // decodes the whole frame and checks framing, bytes and end-of-frame timing.
    // Returns at the falling edge after the frame_done edge.
    task automatic run_frame(input string tag, input bit sel, input int cpb, input vec_t v,
                             input bit hold, input bit disturb, output int waited);
        logic [7:0] got [5];
        logic [7:0] expb [5];
        int last;
        int fd_pos;
        int fd_cnt;
        int ready_leak;
        int framing_err;
        int j;
        int b;
        int k;
        last        = 10 * NB * cpb;
        fd_pos      = -1;
        fd_cnt      = 0;
        ready_leak  = 0;
        framing_err = 0;
        expb[0] = 8'hA5; expb[1] = v.b1; expb[2] = v.b2; expb[3] = v.b3; expb[4] = v.b4;
        for (int i = 0; i < 5; i++) got[i] = 8'h00;

        drive(sel, 1'b1, v.cmd, v.x, v.y);
        waited = 0;
        while (get_ready(sel) !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (get_ready(sel) !== 1'b1) begin
            check({tag, "_accept_timeout"}, 32'(0), 32'(1));
            drive(sel, 1'b0, v.cmd, v.x, v.y);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_low_after_accept"}, 32'(get_ready(sel)), 32'(0));
        check({tag, "_busy_high_after_accept"}, 32'(get_busy(sel)), 32'(1));
        if (!hold && !disturb) drive(sel, 1'b0, v.cmd, v.x, v.y);

        for (int pos = 0; pos <= last; pos++) begin
            if (pos > 0) @(negedge clk);
            if (get_fd(sel) === 1'b1) begin
                fd_cnt++;
                if (fd_pos < 0) fd_pos = pos;
            end
            if (pos < last) begin
                if (get_ready(sel) !== 1'b0) ready_leak++;
                if ((pos % cpb) == (cpb / 2)) begin
                    j = pos / cpb;
                    b = j / 10;
                    k = j % 10;
                    if (k == 0) begin
                        if (get_tx(sel) !== 1'b0) framing_err++;
                    end else if (k == 9) begin
                        if (get_tx(sel) !== 1'b1) framing_err++;
                    end else begin
                        got[b][k-1] = get_tx(sel);
                    end
                end
                if (disturb)
                    drive(sel, pos[0], 3'($urandom), 6'($urandom), 6'($urandom));
            end else begin
                check({tag, "_ready_at_end"}, 32'(get_ready(sel)), 32'(1));
                check({tag, "_tx_idle_at_end"}, 32'(get_tx(sel)), 32'(1));
                if (!hold) drive(sel, 1'b0, v.cmd, v.x, v.y);
            end
        end
        check({tag, "_frame_done_pos"}, 32'(fd_pos), 32'(last));
        check({tag, "_frame_done_count"}, 32'(fd_cnt), 32'(1));
        check({tag, "_ready_leak"}, 32'(ready_leak), 32'(0));
        check({tag, "_framing"}, 32'(framing_err), 32'(0));
        for (int i = 0; i < NB; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(expb[i]));
    endtask

    vec_t vecs [4];
    vec_t vr;
    vec_t v6;
    int   waited;
    int   fd_seen;

    initial begin
        //              cmd   x      y      B1     B2     B3     B4 (xor)
        vecs[0] = '{3'd5, 6'd17, 6'd42, 8'h05, 8'h11, 8'h2A, 8'h3E};
        vecs[1] = '{3'd7, 6'd63, 6'd63, 8'h07, 8'h3F, 8'h3F, 8'h07};
        vecs[2] = '{3'd0, 6'd0,  6'd0,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{3'd2, 6'd42, 6'd21, 8'h02, 8'h2A, 8'h15, 8'h3D};
        vr      = '{3'd3, 6'd9,  6'd50, 8'h03, 8'h09, 8'h32, 8'h38};
        v6      = '{3'd1, 6'd0,  6'd0,  8'h01, 8'h00, 8'h00, 8'h01};

        rstn = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 6'd0, 6'd0);
        drive(1'b1, 1'b0, 3'd0, 6'd0, 6'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 32'(tx4), 32'(1));
        check("reset_ready", 32'(rif4.report_ready), 32'(1));
        check("reset_busy", 32'(busy4), 32'(0));
        check("reset_frame_done", 32'(fd4), 32'(0));
        check("reset_tx_cpb1", 32'(tx1), 32'(1));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors; the last one also toggles valid/data mid-frame.
        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("vec%0d", i), 1'b0, 4, vecs[i], 1'b0, (i == 3), waited);
            repeat (3) @(negedge clk);
        end

        // Back-to-back: valid held, second accept on the edge after frame_done.
        run_frame("b2b_first", 1'b0, 4, vecs[0], 1'b1, 1'b0, waited);
        run_frame("b2b_second", 1'b0, 4, vecs[1], 1'b0, 1'b0, waited);
        check("b2b_accept_wait", 32'(waited), 32'(0));
        repeat (3) @(negedge clk);

        // Reset mid-frame during B2 bit 3 (bit slot 24, mid-bit position 98).
        drive(1'b0, 1'b1, vr.cmd, vr.x, vr.y);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, vr.cmd, vr.x, vr.y);
        repeat (98) @(negedge clk);
        check("rst_mid_tx_b2bit3", 32'(tx4), 32'(1));
        check("rst_mid_busy_before", 32'(busy4), 32'(1));
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_tx", 32'(tx4), 32'(1));
        check("rst_mid_ready", 32'(rif4.report_ready), 32'(1));
        check("rst_mid_busy", 32'(busy4), 32'(0));
        check("rst_mid_frame_done", 32'(fd4), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        fd_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fd4 !== 1'b0 || tx4 !== 1'b1) fd_seen++;
        end
        check("rst_mid_no_activity_after", 32'(fd_seen), 32'(0));
        run_frame("after_reset", 1'b0, 4, vecs[3], 1'b0, 1'b0, waited);
        repeat (3) @(negedge clk);

        // One clock per bit.
        run_frame("cpb1", 1'b1, 1, v6, 1'b0, 1'b0, waited);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
